// File: rtl/scr1_mem_arb_pkg.sv
// Shared memory-interface enums plus arbiter owner IDs and default tracking depth.
package scr1_mem_arb_pkg;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  localparam int   SCR1_ARB_DEPTH_DFLT = 2;
  localparam logic SCR1_ARB_ID_IMEM    = 1'b0;
  localparam logic SCR1_ARB_ID_DMEM    = 1'b1;

endpackage : scr1_mem_arb_pkg

// File: rtl/scr1_arb_order_fifo.sv
// Owner-ID FIFO recording which port issued each accepted bridge request,
// so in-order responses can be routed back.
module scr1_arb_order_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  logic pop_i,
  input  logic id_i,
  output logic id_o,
  output logic full_o,
  output logic empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] id_mem_q;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_s, pop_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_s  = push_i & ~full_o;
  assign pop_s   = pop_i & ~empty_o;
  assign id_o    = id_mem_q[rd_ptr_q];

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_s  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_mem_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_s) begin
        id_mem_q[wr_ptr_q] <= id_i;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule : scr1_arb_order_fifo

// File: rtl/scr1_mem_arb.sv
// Two-port (instruction/data) arbiter onto one memory bridge with round-robin
// grant, stall lock and in-order response routing.
module scr1_mem_arb
  import scr1_mem_arb_pkg::*;
#(
  parameter int SCR1_ARB_DEPTH  = SCR1_ARB_DEPTH_DFLT,
  parameter int SCR1_ADDR_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       imem_req_i,
  output logic                       imem_req_ack_o,
  input  logic [SCR1_ADDR_WIDTH-1:0] imem_addr_i,
  output logic [31:0]                imem_rdata_o,
  output type_scr1_mem_resp_e        imem_resp_o,
  input  logic                       dmem_req_i,
  output logic                       dmem_req_ack_o,
  input  type_scr1_mem_cmd_e         dmem_cmd_i,
  input  type_scr1_mem_width_e       dmem_width_i,
  input  logic [SCR1_ADDR_WIDTH-1:0] dmem_addr_i,
  input  logic [31:0]                dmem_wdata_i,
  output logic [31:0]                dmem_rdata_o,
  output type_scr1_mem_resp_e        dmem_resp_o,
  output logic                       mem_req_o,
  input  logic                       mem_req_ack_i,
  output type_scr1_mem_cmd_e         mem_cmd_o,
  output type_scr1_mem_width_e       mem_width_o,
  output logic [SCR1_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]                mem_wdata_o,
  input  logic [31:0]                mem_rdata_i,
  input  type_scr1_mem_resp_e        mem_resp_i
);

  logic lock_q, lock_id_q, rr_last_q;
  logic sel_s, sel_req_s, xfer_s;
  logic fifo_full_s, fifo_empty_s, head_id_s, pop_s;

  // Grant selection: a stalled request keeps the bus, otherwise round-robin on ties
  always_comb begin
    sel_s = SCR1_ARB_ID_IMEM;
    if (lock_q) begin
      sel_s = lock_id_q;
    end else if (imem_req_i && dmem_req_i) begin
      sel_s = ~rr_last_q;
    end else if (dmem_req_i) begin
      sel_s = SCR1_ARB_ID_DMEM;
    end else begin
      sel_s = SCR1_ARB_ID_IMEM;
    end
  end

  assign sel_req_s      = (sel_s == SCR1_ARB_ID_DMEM) ? dmem_req_i : imem_req_i;
  assign mem_req_o      = sel_req_s & ~fifo_full_s;
  assign xfer_s         = mem_req_o & mem_req_ack_i;
  assign imem_req_ack_o = xfer_s & (sel_s == SCR1_ARB_ID_IMEM);
  assign dmem_req_ack_o = xfer_s & (sel_s == SCR1_ARB_ID_DMEM);
  assign pop_s          = (mem_resp_i != SCR1_MEM_RESP_NOTRDY) & ~fifo_empty_s;

  // Request mux; instruction fetches are always word reads
  always_comb begin
    if (sel_s == SCR1_ARB_ID_DMEM) begin
      mem_cmd_o   = dmem_cmd_i;
      mem_width_o = dmem_width_i;
      mem_addr_o  = dmem_addr_i;
      mem_wdata_o = dmem_wdata_i;
    end else begin
      mem_cmd_o   = SCR1_MEM_CMD_RD;
      mem_width_o = SCR1_MEM_WIDTH_WORD;
      mem_addr_o  = imem_addr_i;
      mem_wdata_o = 32'h0000_0000;
    end
  end

  // Response routing to the owner at the FIFO head; nothing outstanding means nobody gets it
  always_comb begin
    imem_resp_o  = SCR1_MEM_RESP_NOTRDY;
    dmem_resp_o  = SCR1_MEM_RESP_NOTRDY;
    imem_rdata_o = 32'h0000_0000;
    dmem_rdata_o = 32'h0000_0000;
    if (!fifo_empty_s) begin
      if (head_id_s == SCR1_ARB_ID_DMEM) begin
        dmem_resp_o  = mem_resp_i;
        dmem_rdata_o = mem_rdata_i;
      end else begin
        imem_resp_o  = mem_resp_i;
        imem_rdata_o = mem_rdata_i;
      end
    end else begin
      imem_resp_o = SCR1_MEM_RESP_NOTRDY;
      dmem_resp_o = SCR1_MEM_RESP_NOTRDY;
    end
  end

  // Lock and round-robin state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q    <= 1'b0;
      lock_id_q <= SCR1_ARB_ID_IMEM;
      rr_last_q <= SCR1_ARB_ID_DMEM;
    end else if (xfer_s) begin
      lock_q    <= 1'b0;
      rr_last_q <= sel_s;
    end else if (mem_req_o) begin
      lock_q    <= 1'b1;
      lock_id_q <= sel_s;
    end else begin
      lock_q    <= lock_q;
    end
  end

  scr1_arb_order_fifo #(
    .DEPTH (SCR1_ARB_DEPTH)
  ) u_order_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (xfer_s),
    .pop_i   (pop_s),
    .id_i    (sel_s),
    .id_o    (head_id_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

endmodule : scr1_mem_arb

// File: doc/scr1_mem_arb.md
SCR1_MEM_ARB -- requirements
Module: scr1_mem_arb

Interface
REQ-001 Parameter SCR1_ARB_DEPTH, default 2, power of 2: number of outstanding transactions tracked; SHALL equal the downstream bridge request buffer size.
REQ-002 Parameter SCR1_ADDR_WIDTH, default 32: address width on all ports.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 imem_req  in  1  instruction port request; read-only, word width implied.
REQ-006 imem_req_ack  out  1  instruction request accepted this cycle.
REQ-007 imem_addr  in  SCR1_ADDR_WIDTH  instruction fetch address.
REQ-008 imem_rdata  out  32  instruction read data.
REQ-009 imem_resp  out  type_scr1_mem_resp_e  instruction response.
REQ-010 dmem_req  in  1  data port request.
REQ-011 dmem_req_ack  out  1  data request accepted this cycle.
REQ-012 dmem_cmd  in  type_scr1_mem_cmd_e  read/write.
REQ-013 dmem_width  in  type_scr1_mem_width_e  byte/hword/word.
REQ-014 dmem_addr  in  SCR1_ADDR_WIDTH  data address.
REQ-015 dmem_wdata  in  32  write data.
REQ-016 dmem_rdata  out  32  read data.
REQ-017 dmem_resp  out  type_scr1_mem_resp_e  data response.
REQ-018 mem_req/mem_cmd/mem_width/mem_addr/mem_wdata  out  1/enum/enum/SCR1_ADDR_WIDTH/32  shared request to bridge.
REQ-019 mem_req_ack  in  1, mem_rdata  in  32, mem_resp  in  type_scr1_mem_resp_e: bridge acceptance and in-order response.

Function
REQ-020 Grant: only one requester SHALL be selected per cycle; mem_req = selected req & ~order_full.
REQ-021 Both requesting with no lock: select the port not granted last (round-robin flag rr_last, updated on each accepted transfer).
REQ-022 Lock: if selected request is presented and mem_req_ack=0, lock flag SHALL set and selection SHALL be held until that port's transfer is accepted.
REQ-023 mem_cmd/width/addr/wdata SHALL mux from selected port; IMEM selected forces cmd=RD, width=WORD, wdata='0.
REQ-024 x_req_ack = selected(x) & mem_req & mem_req_ack, combinational, zero latency; non-selected ack SHALL be 0.
REQ-025 Order FIFO: push owner ID (0=IMEM,1=DMEM) on mem_req & mem_req_ack; pop when mem_resp != NOTRDY and FIFO non-empty.
REQ-026 Response routing: head owner receives mem_resp and mem_rdata same cycle; other port gets NOTRDY and rdata='0.
REQ-027 Full (count==SCR1_ARB_DEPTH): mem_req SHALL be 0 and both acks 0, even if a pop occurs that cycle.
REQ-028 Empty with mem_resp != NOTRDY: both ports SHALL see NOTRDY; no pop; pointers unchanged.
REQ-029 Simultaneous push and pop (not full): count unchanged, both pointers advance; pointers wrap modulo SCR1_ARB_DEPTH.
REQ-030 RDY_ER responses SHALL be forwarded and popped identically to RDY_OK.

Reset
REQ-031 rst_n low SHALL asynchronously clear FIFO pointers and count, lock flag, and set rr_last=DMEM (IMEM wins first tie).
REQ-032 Reset mid-operation discards outstanding ownership; responses arriving before any new push follow REQ-028.

Structure
REQ-033 Memory enums come from the shared memif package; owner ID encoding and depth default SHALL be localparams in a shared scr1_arb package entry.
REQ-034 Order FIFO SHALL be a separate sub-module scr1_arb_order_fifo (push, pop, id in/out, full, empty).

Verification
REQ-035 Both request same cycle after reset, mem_req_ack=1 -> IMEM acked cycle 1, DMEM cycle 2; responses OK/OK routed IMEM then DMEM.
REQ-036 DMEM write 0x1000 held with mem_req_ack=0 for 3 cycles while IMEM requests -> DMEM stays selected, acked cycle 4, then IMEM.
REQ-037 Two accepted reads, no responses, third request -> mem_req=0, acks 0 until first response pops; accepted cycle after pop.
REQ-038 mem_resp=RDY_OK with empty FIFO -> imem_resp=dmem_resp=NOTRDY, count stays 0.
REQ-039 IMEM outstanding, bridge returns RDY_ER rdata=0xDEADBEEF -> imem_resp=RDY_ER, imem_rdata=0xDEADBEEF, dmem_resp=NOTRDY.
REQ-040 rst_n asserted with 2 outstanding -> count=0 immediately; next grant to IMEM on tie.
